fp16_mul_operand_prep: RTL and testbench
========================================

Name: fp16_mul_operand_prep

Overview:
- Upstream stage of the FP16 multiplier.
- Accepts a raw IEEE 754 half-precision operand pair and classifies each operand as zero, subnormal, normal, infinity or NaN.
- Special cases are resolved directly to a final 16-bit result.
- Subnormal operands are normalized iteratively, one left shift per cycle, so the multiplier datapath only ever sees mantissas with the leading one at bit 10.
- Valid/ready handshakes on both sides.

Parameters:
- BIAS, 15, exponent bias of FP16.
- EXP_W, 7, width of the signed unbiased exponent outputs.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept a pair this cycle.
- in_a  in  16  raw FP16 operand A.
- in_b  in  16  raw FP16 operand B.
- out_valid  out  1  output fields valid.
- out_ready  in  1  multiplier accepts output.
- out_sign  out  1  in_a[15] XOR in_b[15].
- out_man_a  out  11  normalized mantissa A including leading one.
- out_man_b  out  11  normalized mantissa B including leading one.
- out_exp_a  out  EXP_W  signed unbiased exponent A.
- out_exp_b  out  EXP_W  signed unbiased exponent B.
- out_special  out  1  out_result holds the final product; the multiplier must bypass.
- out_result  out  16  special-case product; 0 when out_special=0.

Behaviour:
- States are IDLE, NORM and HOLD. Reset (rst_n=0 at a clock edge) forces:
  - state=IDLE;
  - out_valid=0, out_special=0, out_result=0, out_sign=0;
  - all mantissa and exponent outputs 0.
  - Reset wins over every other event, including mid-NORM; any in-flight pair is discarded.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
- Classification per operand, using e=[14:10] and m=[9:0]:
  - zero: e=0, m=0;
  - sub: e=0, m!=0;
  - normal: 0<e<31;
  - inf: e=31, m=0;
  - nan: e=31, m!=0.
- Special priority, evaluated at accept:
  1. either operand NaN, or inf×zero → out_result=16'h7E00, out_sign=0;
  2. either operand inf → {sign,5'h1F,10'h0};
  3. either operand zero → {sign,15'h0}.
  - Any special case → out_special=1, next state HOLD. Mantissa and exponent outputs are then don't-care, driven 0.
- Non-special case, loaded at accept:
  - man = {e!=0, m};
  - exp = (e!=0) ? e−BIAS : 1−BIAS (i.e. −14), sign-extended to EXP_W.
  - If both man[10]=1 → HOLD, otherwise → NORM.
- NORM, at each edge:
  - every operand with man[10]=0 gets man<<=1 and exp−=1;
  - operands already normalized hold their values;
  - when both would be normalized after this edge → HOLD.
  - in_ready=0 and out_valid=0 throughout NORM.
- Shift count per subnormal is s = 10 − (index of leading one of m), range 1..10. The smallest exponent produced is −24.
- HOLD:
  - out_valid=1 and all outputs stable;
  - out_ready=1 → pair consumed; if in_valid is also high, the new pair is accepted on the same edge (back-to-back), otherwise → IDLE.
  - out_ready=0 → hold indefinitely.
- Latency from the accept edge to out_valid visible:
  - 1 cycle for normal or special pairs;
  - 1 + max(s_a, s_b) cycles when a subnormal is present.
- Throughput is 1 pair/cycle on the normal path.
- out_valid never deasserts without a handshake or reset.

Test Plan:
- 0x3C00 × 0x4000 (1.0 × 2.0) → 1 cycle later:
  - out_valid=1, out_special=0;
  - man_a=man_b=0x400, exp_a=0, exp_b=1, sign=0.
- 0x0001 × 0x3C00 → out_valid exactly 11 cycles after accept, in_ready=0 meanwhile:
  - man_a=0x400, exp_a=−24;
  - man_b=0x400, exp_b=0.
- 0x0200 × 0x8001 → shifts 1 and 10, out_valid after 11 cycles:
  - exp_a=−15, exp_b=−24, sign=1.
- Specials:
  - 0x7C00 × 0x0000 → out_special=1, out_result=0x7E00;
  - 0xFC00 × 0x3C00 → 0xFC00;
  - 0x8000 × 0x4000 → 0x8000;
  - 0x7E01 × 0x7C00 → 0x7E00.
- Back-to-back stream of 4 normal pairs with out_ready=1 → one result per cycle, in order. Drop out_ready for 3 cycles mid-stream → outputs held stable and in_ready=0 for those 3 cycles.
- Accept 0x0001 × 0x0001, assert rst_n=0 on the 4th NORM cycle → next cycle:
  - state IDLE, out_valid=0, in_ready=1;
  - a subsequent 0x3C00 × 0x3C00 completes normally with exp=0.

Source files
------------

// File: rtl/fp16_mul_operand_prep.sv
// Operand preparation stage for the FP16 multiplier: classifies both operands,
// resolves special products, and normalizes subnormals one shift per cycle.
module fp16_mul_operand_prep #(
  parameter int BIAS  = 15,
  parameter int EXP_W = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_a,
  input  logic [15:0]             in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [10:0]             out_man_a,
  output logic [10:0]             out_man_b,
  output logic signed [EXP_W-1:0] out_exp_a,
  output logic signed [EXP_W-1:0] out_exp_b,
  output logic                    out_special,
  output logic [15:0]             out_result
);

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } cls_t;

  function automatic cls_t classify(input logic [15:0] x);
    cls_t c;
    c.zero = (x[14:10] == 5'd0)  && (x[9:0] == 10'd0);
    c.inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    c.nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    return c;
  endfunction

  // Subnormals share the exponent of the smallest normal (1 - BIAS).
  function automatic logic signed [EXP_W-1:0] unbias(input logic [4:0] e);
    return (e != 5'd0) ? EXP_W'(int'(e) - BIAS) : EXP_W'(1 - BIAS);
  endfunction

  state_t state;
  cls_t   cls_a, cls_b;
  logic   accept;

  logic                    ld_sign, ld_special;
  logic [15:0]             ld_result;
  logic [10:0]             ld_man_a, ld_man_b;
  logic signed [EXP_W-1:0] ld_exp_a, ld_exp_b;
  state_t                  ld_state;

  logic [10:0]             sh_man_a, sh_man_b;
  logic signed [EXP_W-1:0] sh_exp_a, sh_exp_b;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign cls_a    = classify(in_a);
  assign cls_b    = classify(in_b);

  always_comb begin
    // NOTE: every output of this block gets a default up front so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    ld_sign    = in_a[15] ^ in_b[15];
    ld_special = 1'b0;
    ld_result  = 16'h0000;
    ld_man_a   = '0;
    ld_man_b   = '0;
    ld_exp_a   = '0;
    ld_exp_b   = '0;
    if (cls_a.nan || cls_b.nan || (cls_a.inf && cls_b.zero) || (cls_a.zero && cls_b.inf)) begin
      ld_special = 1'b1;
      ld_sign    = 1'b0;
      ld_result  = 16'h7E00;
    end else if (cls_a.inf || cls_b.inf) begin
      ld_special = 1'b1;
      ld_result  = {ld_sign, 5'h1F, 10'h000};
    end else if (cls_a.zero || cls_b.zero) begin
      ld_special = 1'b1;
      ld_result  = {ld_sign, 15'h0000};
    end else begin
      ld_man_a = {in_a[14:10] != 5'd0, in_a[9:0]};
      ld_man_b = {in_b[14:10] != 5'd0, in_b[9:0]};
      ld_exp_a = unbias(in_a[14:10]);
      ld_exp_b = unbias(in_b[14:10]);
    end
    ld_state = (ld_special || (ld_man_a[10] && ld_man_b[10])) ? HOLD : NORM;
  end

  // One normalization step: only operands still missing the leading one move.
  always_comb begin
    sh_man_a = out_man_a[10] ? out_man_a : {out_man_a[9:0], 1'b0};
    sh_man_b = out_man_b[10] ? out_man_b : {out_man_b[9:0], 1'b0};
    sh_exp_a = out_man_a[10] ? out_exp_a : out_exp_a - EXP_W'(1);
    sh_exp_b = out_man_b[10] ? out_exp_b : out_exp_b - EXP_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_special <= 1'b0;
      out_result  <= 16'h0000;
      out_sign    <= 1'b0;
      out_man_a   <= '0;
      out_man_b   <= '0;
      out_exp_a   <= '0;
      out_exp_b   <= '0;
    end else if (accept) begin
      state       <= ld_state;
      out_valid   <= (ld_state == HOLD);
      out_special <= ld_special;
      out_result  <= ld_result;
      out_sign    <= ld_sign;
      out_man_a   <= ld_man_a;
      out_man_b   <= ld_man_b;
      out_exp_a   <= ld_exp_a;
      out_exp_b   <= ld_exp_b;
    end else begin
      case (state)
        NORM: begin
          out_man_a <= sh_man_a;
          out_man_b <= sh_man_b;
          out_exp_a <= sh_exp_a;
          out_exp_b <= sh_exp_b;
          if (sh_man_a[10] && sh_man_b[10]) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_operand_prep.sv
// Self-checking bench for fp16_mul_operand_prep: an arithmetic reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_fp16_mul_operand_prep;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_a, in_b;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [10:0]       out_man_a, out_man_b;
  logic signed [6:0] out_exp_a, out_exp_b;
  logic              out_special;
  logic [15:0]       out_result;

  fp16_mul_operand_prep #(.BIAS(15), .EXP_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_man_a(out_man_a), .out_man_b(out_man_b),
    .out_exp_a(out_exp_a), .out_exp_b(out_exp_b),
    .out_special(out_special), .out_result(out_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              sign;
    logic [10:0]       ma, mb;
    logic signed [6:0] ea, eb;
    logic              sp;
    logic [15:0]       res;
    int                lat;
    int                acc;
  } txn_t;

  txn_t q[$];

  // Real-number view: value = 1.f * 2^exp; a subnormal m*2^-24 is doubled until
  // it reaches the [1024,2048) range, each doubling costing one cycle.
  function automatic void prep_op(input logic [15:0] x, output logic [10:0] man,
                                  output logic signed [6:0] ex, output int s);
    int e, m;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    man = '0; ex = '0; s = 0;
    if (e != 0) begin
      man = 11'(1024 + m);
      ex  = 7'(e - 15);
    end else if (m != 0) begin
      while (m < 1024) begin
        m = m * 2;
        s++;
      end
      man = 11'(m);
      ex  = 7'(-14 - s);
    end
  endfunction

  function automatic txn_t model(input logic [15:0] a, input logic [15:0] b);
    txn_t t;
    int sa, sb;
    bit za, zb, ia, ib, na, nb;
    za = (a[14:10] == 0) && (a[9:0] == 0);
    zb = (b[14:10] == 0) && (b[9:0] == 0);
    ia = (a[14:10] == 31) && (a[9:0] == 0);
    ib = (b[14:10] == 31) && (b[9:0] == 0);
    na = (a[14:10] == 31) && (a[9:0] != 0);
    nb = (b[14:10] == 31) && (b[9:0] != 0);
    t.sign = a[15] ^ b[15];
    t.ma = '0; t.mb = '0; t.ea = '0; t.eb = '0;
    t.sp = 1'b1; t.res = 16'h0000; t.lat = 1; t.acc = 0;
    if (na || nb || (ia && zb) || (za && ib)) begin
      t.res  = 16'h7E00;
      t.sign = 1'b0;
    end else if (ia || ib) begin
      t.res = t.sign ? 16'hFC00 : 16'h7C00;
    end else if (za || zb) begin
      t.res = t.sign ? 16'h8000 : 16'h0000;
    end else begin
      t.sp = 1'b0;
      prep_op(a, t.ma, t.ea, sa);
      prep_op(b, t.mb, t.eb, sb);
      t.lat = 1 + ((sa > sb) ? sa : sb);
    end
    return t;
  endfunction

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    bit   ev, exp_ir;
    txn_t t;
    if (mon_en) begin
      ev     = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
      exp_ir = (q.size() == 0) || (ev && out_ready);
      check("mon_out_valid", 32'(out_valid), 32'(ev));
      check("mon_in_ready", 32'(in_ready), 32'(exp_ir));
      if (ev) begin
        check("mon_special", 32'(out_special), 32'(q[0].sp));
        check("mon_result", 32'(out_result), 32'(q[0].res));
        check("mon_sign", 32'(out_sign), 32'(q[0].sign));
        check("mon_man_a", 32'(out_man_a), 32'(q[0].ma));
        check("mon_man_b", 32'(out_man_b), 32'(q[0].mb));
        check("mon_exp_a", 32'(out_exp_a), 32'(q[0].ea));
        check("mon_exp_b", 32'(out_exp_b), 32'(q[0].eb));
      end
      if (!rst_n) begin
        q.delete();
      end else begin
        if (ev && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) begin
          t = model(in_a, in_b);
          t.acc = cyc;
          q.push_back(t);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int k;
    in_a = a; in_b = b; in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 40) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic sg, input logic sp, input logic [15:0] res,
                         input logic [10:0] ma, input logic [10:0] mb,
                         input int ea, input int eb);
    int k;
    send(a, b);
    k = 1;
    forever begin
      @(negedge clk);
      if (out_valid || k > 40) break;
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(lat));
    check({name, "_special"}, 32'(out_special), 32'(sp));
    check({name, "_result"}, 32'(out_result), 32'(res));
    check({name, "_sign"}, 32'(out_sign), 32'(sg));
    check({name, "_man_a"}, 32'(out_man_a), 32'(ma));
    check({name, "_man_b"}, 32'(out_man_b), 32'(mb));
    check({name, "_exp_a"}, 32'(out_exp_a), 32'(ea));
    check({name, "_exp_b"}, 32'(out_exp_b), 32'(eb));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_special", 32'(out_special), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_fields", {out_sign, out_man_a, out_man_b, out_exp_a, out_exp_b}, 32'd0);
    mon_en = 1'b1;

    run_lit("one_x_two", 16'h3C00, 16'h4000, 1, 0, 0, 16'h0000, 11'h400, 11'h400, 0, 1);
    run_lit("sub_min", 16'h0001, 16'h3C00, 11, 0, 0, 16'h0000, 11'h400, 11'h400, -24, 0);
    run_lit("sub_pair", 16'h0200, 16'h8001, 11, 1, 0, 16'h0000, 11'h400, 11'h400, -15, -24);
    run_lit("inf_zero", 16'h7C00, 16'h0000, 1, 0, 1, 16'h7E00, 11'h000, 11'h000, 0, 0);
    run_lit("ninf_one", 16'hFC00, 16'h3C00, 1, 1, 1, 16'hFC00, 11'h000, 11'h000, 0, 0);
    run_lit("nzero_two", 16'h8000, 16'h4000, 1, 1, 1, 16'h8000, 11'h000, 11'h000, 0, 0);
    run_lit("nan_inf", 16'h7E01, 16'h7C00, 1, 0, 1, 16'h7E00, 11'h000, 11'h000, 0, 0);
    run_lit("sub_mid", 16'h0010, 16'h0300, 7, 0, 0, 16'h0000, 11'h400, 11'h600, -20, -15);

    // Back-to-back normal stream with a 3-cycle stall after the third result.
    send(16'h3C00, 16'h4000);
    send(16'h4400, 16'h3800);
    send(16'hC200, 16'h3E00);
    out_ready = 1'b0;
    in_a = 16'h7BFF; in_b = 16'h0400; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_man_a", 32'(out_man_a), 32'h600);
      check("stall_exp_a", 32'(out_exp_a), 32'd1);
      check("stall_sign", 32'(out_sign), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h7BFF, 16'h0400);
    @(negedge clk);
    check("stream_last_man_a", 32'(out_man_a), 32'h7FF);
    check("stream_last_exp_b", 32'(out_exp_b), -32'sd14);
    @(posedge clk); #1;

    // Reset in the middle of normalization discards the pair.
    send(16'h0001, 16'h0001);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_man_a", 32'(out_man_a), 32'd0);
    run_lit("after_rst", 16'h3C00, 16'h3C00, 1, 0, 0, 16'h0000, 11'h400, 11'h400, 0, 0);

    repeat (3) @(posedge clk);
    check("drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
